eth_tx_arp_sched: RTL and testbench
===================================

# eth_tx_arp_sched

ARP transmit scheduler sitting directly in front of the GMII transmit path (`eth_tx`). It arbitrates round-robin between two requesters: ARP replies generated by the receive side, and ARP requests issued by the local address-resolution logic. It latches the winning destination fields, pulses `tx_frame_start`, holds the fields stable until the frame completes, and then enforces an inter-frame gap before the next grant.

## Interface
Parameters:
- `IFG_CYCLES`, default 12: idle cycles inserted after `tx_frame_done` before the next grant; legal range 0–255.
- `TIMEOUT_CYCLES`, default 2048: maximum BUSY duration before the watchdog fires (see Configuration); legal range 1–65535.

Ports. One clock; reset is synchronous and active-high.
- `aclk`  in  1  clock; same domain as `gmii_tx_clk`.
- `areset`  in  1  synchronous, active-high reset.
- `rply_valid`  in  1  reply requester has a frame pending.
- `rply_ready`  out  1  reply request accepted on `rply_valid && rply_ready`.
- `rply_mac`  in  48  reply target MAC address.
- `rply_ip`  in  32  reply target IP address.
- `rqst_valid`  in  1  request requester has a frame pending.
- `rqst_ready`  out  1  request accepted on `rqst_valid && rqst_ready`.
- `rqst_ip`  in  32  IP address to resolve.
- `tx_frame_start`  out  1  one-cycle start pulse to `eth_tx`.
- `tx_frame_done`  in  1  frame-complete pulse from `eth_tx`.
- `mac_d_addr`  out  48  destination MAC address to `eth_tx`.
- `ip_d_addr`  out  32  destination IP address to `eth_tx`.
- `arp_oper`  out  1  0 = request, 1 = reply.
- `busy`  out  1  high in every state except IDLE.
- `frame_cnt`  out  16  count of completed frames; wraps from 0xFFFF to 0.
- `timeout_err`  out  1  one-cycle watchdog pulse.

## Operation
States:
- IDLE → START on accept.
- START → BUSY unconditionally.
- BUSY → IFG on `tx_frame_done`, or on timeout.
- IFG → IDLE after `IFG_CYCLES` cycles.
- With `IFG_CYCLES = 0`, BUSY → IDLE directly.

Arbitration (IDLE only, combinational ready):
- One valid requester: its ready is high.
- Both valid: grant goes to the requester not named by `last_grant`. `last_grant` updates on every accept.
- After reset `last_grant` = request, so reply wins the first tie.
- Exactly one ready is high at a time. Both readys are 0 outside IDLE.

Latching on accept:
- Reply accept: `mac_d_addr <= rply_mac`, `ip_d_addr <= rply_ip`, `arp_oper <= 1`.
- Request accept: `mac_d_addr <= 48'hFFFF_FFFF_FFFF`, `ip_d_addr <= rqst_ip`, `arp_oper <= 0`.
- These fields hold unchanged until the next accept.

Completion and counters:
- `tx_frame_done` is sampled only in BUSY. A done in IDLE, START or IFG is ignored.
- `frame_cnt` increments on the BUSY-state done only; a timeout does not increment it.
- The IFG counter loads `IFG_CYCLES - 1` on BUSY exit and decrements to 0.

Reset values: `tx_frame_start` 0, `rply_ready` 0, `rqst_ready` 0, `mac_d_addr` 0, `ip_d_addr` 0, `arp_oper` 0, `busy` 0, `frame_cnt` 0, `timeout_err` 0; state IDLE; `last_grant` = request.

Reset mid-frame: state returns to IDLE and the latched request is dropped. This block does not reset `eth_tx`.

## Timing
- Accept at cycle T.
- `tx_frame_start` is high only at T+1; `busy` is high from T+1.
- Address fields are valid from T+1.
- `tx_frame_done` arrives at cycle D (earliest D = T+2).
- `frame_cnt` updates at D+1.
- IFG occupies D+1 … D+`IFG_CYCLES`.
- Earliest next ready is at D+`IFG_CYCLES`+1. With `IFG_CYCLES = 0`, earliest next ready is D+1.
- Minimum accept-to-accept spacing is `IFG_CYCLES` + 3 cycles.

## Configuration
- Macro: `ETH_TX_ARP_SCHED_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on BUSY entry and increments each BUSY cycle.
  - On reaching `TIMEOUT_CYCLES` without `tx_frame_done`: `timeout_err` pulses for one cycle, the FSM moves to IFG (or IDLE when `IFG_CYCLES = 0`), and `frame_cnt` is unchanged.
  - A done in the same cycle as the timeout wins: normal completion, no `timeout_err`.
- Undefined: no counter is built, `timeout_err` is tied to 0, and BUSY waits indefinitely.

## Test plan
- Single reply: `rply_valid=1`, `rply_mac=0x0011_2233_4455`, `rply_ip=0xC0A8_0001`, accept at T → `tx_frame_start` at T+1, `arp_oper=1`, fields match; done at T+10 → `frame_cnt=1` at T+11, next ready at T+23 with defaults.
- Tie: both valid continuously for four frames → grants in the order reply, request, reply, request. Request frames show `mac_d_addr=FFFF_FFFF_FFFF`, `arp_oper=0`.
- Stray done: `tx_frame_done` pulsed in IDLE and in the IFG cycles → no state change, `frame_cnt` unchanged.
- `IFG_CYCLES=0`: done at D → ready high at D+1, next `tx_frame_start` at D+2.
- Reset mid-frame: `areset` asserted in BUSY → the following cycle shows all outputs at reset values; a subsequent request is accepted normally.
- Timeout (macro defined, `TIMEOUT_CYCLES=16`): no done after accept → `timeout_err` pulses exactly once, 16 BUSY cycles after BUSY entry, then IFG; `frame_cnt` stays 0.

Source files
------------

// File: rtl/eth_tx_arp_sched.sv
// ARP transmit scheduler in front of the GMII transmit path.
// Round-robin arbitration between ARP replies and ARP requests, latches the
// winner's destination fields, pulses tx_frame_start, waits for
// tx_frame_done and then enforces an inter-frame gap.
// Optional BUSY watchdog: define ETH_TX_ARP_SCHED_TIMEOUT_EN to build it.
module eth_tx_arp_sched #(
  parameter int IFG_CYCLES     = 12,   // 0..255
  parameter int TIMEOUT_CYCLES = 2048  // 1..65535
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        rply_valid,
  output logic        rply_ready,
  input  logic [47:0] rply_mac,
  input  logic [31:0] rply_ip,
  input  logic        rqst_valid,
  output logic        rqst_ready,
  input  logic [31:0] rqst_ip,
  output logic        tx_frame_start,
  input  logic        tx_frame_done,
  output logic [47:0] mac_d_addr,
  output logic [31:0] ip_d_addr,
  output logic        arp_oper,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_IFG} state_t;
  typedef enum logic {GRANT_RQST = 1'b0, GRANT_RPLY = 1'b1} grant_t;

  localparam logic [7:0]  IFG_LOAD   = 8'((IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1);
  localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  state_t     state;
  grant_t     last_grant;
  logic [7:0] ifg_cnt;
  logic       timeout_hit;
  logic       frame_end;

  // Round-robin grant, only offered while idle; the previous winner loses a tie.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    rply_ready = 1'b0;
    rqst_ready = 1'b0;
    if (!areset && state == S_IDLE) begin
      rply_ready = rply_valid && (!rqst_valid || last_grant == GRANT_RQST);
      rqst_ready = rqst_valid && (!rply_valid || last_grant == GRANT_RPLY);
    end
  end

`ifdef ETH_TX_ARP_SCHED_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;

  // A done arriving in the final watchdog cycle takes priority over the timeout.
  assign timeout_hit = (state == S_BUSY) && !tx_frame_done && (to_cnt == TIMEOUT_LAST);

  // Watchdog: counts BUSY cycles, held at zero in every other state.
  always_ff @(posedge aclk) begin
    if (areset || state != S_BUSY) to_cnt <= '0;
    else                           to_cnt <= to_cnt + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign frame_end = (state == S_BUSY) && (tx_frame_done || timeout_hit);

  // Scheduler FSM with registered start pulse, latched fields and counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= S_IDLE;
      last_grant     <= GRANT_RQST;
      ifg_cnt        <= '0;
      tx_frame_start <= 1'b0;
      mac_d_addr     <= '0;
      ip_d_addr      <= '0;
      arp_oper       <= 1'b0;
      busy           <= 1'b0;
      frame_cnt      <= '0;
      timeout_err    <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
      tx_frame_start <= 1'b0;
      timeout_err    <= timeout_hit;
      case (state)
        S_IDLE: begin
          if (rply_ready) begin
            mac_d_addr     <= rply_mac;
            ip_d_addr      <= rply_ip;
            arp_oper       <= 1'b1;
            last_grant     <= GRANT_RPLY;
            tx_frame_start <= 1'b1;
            busy           <= 1'b1;
            state          <= S_START;
          end else if (rqst_ready) begin
            mac_d_addr     <= BCAST_MAC;
            ip_d_addr      <= rqst_ip;
            arp_oper       <= 1'b0;
            last_grant     <= GRANT_RQST;
            tx_frame_start <= 1'b1;
            busy           <= 1'b1;
            state          <= S_START;
          end
        end
        S_START: state <= S_BUSY;
        S_BUSY: begin
          if (frame_end) begin
            if (tx_frame_done) frame_cnt <= frame_cnt + 16'd1;
            if (IFG_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              ifg_cnt <= IFG_LOAD;
              state   <= S_IFG;
            end
          end
        end
        S_IFG: begin
          if (ifg_cnt == 8'd0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            ifg_cnt <= ifg_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arp_sched.sv
// Self-checking bench for eth_tx_arp_sched. Three instances share stimulus:
// u[0] IFG=12 (defaults), u[1] IFG=0, u[2] IFG=2 with TIMEOUT=16.
// Only the instance selected by 'sel' is checked in each phase.
module tb_eth_tx_arp_sched;

  logic        clk = 1'b0;
  logic        areset;
  logic        rply_valid, rqst_valid, tx_frame_done;
  logic [47:0] rply_mac;
  logic [31:0] rply_ip, rqst_ip;

  logic        rr_v [3];
  logic        qr_v [3];
  logic        st_v [3];
  logic        op_v [3];
  logic        bz_v [3];
  logic        te_v [3];
  logic [47:0] mac_v [3];
  logic [31:0] ip_v [3];
  logic [15:0] cnt_v [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    eth_tx_arp_sched #(
      .IFG_CYCLES    ((g == 0) ? 12 : (g == 1) ? 0 : 2),
      .TIMEOUT_CYCLES((g == 2) ? 16 : 2048)
    ) u_dut (
      .aclk          (clk),
      .areset        (areset),
      .rply_valid    (rply_valid),
      .rply_ready    (rr_v[g]),
      .rply_mac      (rply_mac),
      .rply_ip       (rply_ip),
      .rqst_valid    (rqst_valid),
      .rqst_ready    (qr_v[g]),
      .rqst_ip       (rqst_ip),
      .tx_frame_start(st_v[g]),
      .tx_frame_done (tx_frame_done),
      .mac_d_addr    (mac_v[g]),
      .ip_d_addr     (ip_v[g]),
      .arp_oper      (op_v[g]),
      .busy          (bz_v[g]),
      .frame_cnt     (cnt_v[g]),
      .timeout_err   (te_v[g])
    );
  end

  always #5 clk = ~clk;

`ifdef ETH_TX_ARP_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        rv, qv;
    logic [47:0] mac;
    logic [31:0] rip, qip;
    logic        exp_rr, exp_qr;
    logic [47:0] exp_mac;
    logic [31:0] exp_ip;
    logic        exp_oper;
    int          done_dly;
    logic        stray;
  } frame_vec_t;

  frame_vec_t  tbl [8];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          sel      = 0;
  logic [15:0] exp_cnt  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rply_valid = 0; rqst_valid = 0; tx_frame_done = 0;
    areset = 1;
    step();
    areset = 0;
    exp_cnt = '0;
  endtask

  // One complete frame on instance 'sel': grant at T, done at T+done_dly,
  // then the gap; ends at the first idle cycle with valids low.
  task automatic run_frame(input frame_vec_t v, input int ifg);
    rply_valid = v.rv; rqst_valid = v.qv;
    rply_mac = v.mac; rply_ip = v.rip; rqst_ip = v.qip;
    #1;
    check("grant", {rr_v[sel], qr_v[sel]}, {v.exp_rr, v.exp_qr});
    step();                                   // T+1
    rply_valid = 0; rqst_valid = 0;
    rply_mac = ~v.mac; rply_ip = ~v.rip; rqst_ip = ~v.qip;
    check("start_pulse", st_v[sel], 1'b1);
    check("busy_on", bz_v[sel], 1'b1);
    check("mac_d_addr", mac_v[sel], v.exp_mac);
    check("ip_d_addr", ip_v[sel], v.exp_ip);
    check("arp_oper", op_v[sel], v.exp_oper);
    step();                                   // T+2
    check("start_once", st_v[sel], 1'b0);
    repeat (v.done_dly - 2) step();           // D
    check("hold_fields", {op_v[sel], ip_v[sel], mac_v[sel][15:0]},
          {v.exp_oper, v.exp_ip, v.exp_mac[15:0]});
    tx_frame_done = 1;
    step();                                   // D+1
    tx_frame_done = 0;
    exp_cnt = exp_cnt + 16'd1;
    check("frame_cnt", cnt_v[sel], exp_cnt);
    if (ifg > 0) begin
      for (int i = 1; i < ifg; i++) begin
        tx_frame_done = v.stray && (i <= 2);
        step();
      end                                     // D+ifg
      tx_frame_done = 0;
      rply_valid = 1; rqst_valid = 1;
      #1;
      check("ifg_last_cycle", {rr_v[sel], qr_v[sel], bz_v[sel]}, 3'b001);
      rply_valid = 0; rqst_valid = 0;
      step();                                 // D+ifg+1
    end
    check("idle_after_gap", bz_v[sel], 1'b0);
    check("cnt_after_gap", cnt_v[sel], exp_cnt);
  endtask

  // Reference model state for the random phase (timestamps, not FSM states).
  logic        m_active, m_last_rply;
  int          m_tacc, m_free_at, m_terr;
  logic [47:0] m_mac;
  logic [31:0] m_ip;
  logic        m_oper;
  logic [15:0] m_cnt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 1, 48'h0011_2233_4455, 32'hC0A8_0001, 32'h0A00_0002, 1, 0, 48'h0011_2233_4455, 32'hC0A8_0001, 1, 10, 0};
    tbl[1] = '{1, 1, 48'h0A0B_0C0D_0E0F, 32'h0A00_0001, 32'h0A00_0002, 0, 1, 48'hFFFF_FFFF_FFFF, 32'h0A00_0002, 0, 2, 1};
    tbl[2] = '{1, 1, 48'h02AA_BBCC_DDEE, 32'hAC10_0001, 32'hAC10_0002, 1, 0, 48'h02AA_BBCC_DDEE, 32'hAC10_0001, 1, 5, 0};
    tbl[3] = '{1, 1, 48'h02AA_BBCC_DDEE, 32'hAC10_0001, 32'hAC10_0002, 0, 1, 48'hFFFF_FFFF_FFFF, 32'hAC10_0002, 0, 3, 1};
    tbl[4] = '{0, 1, 48'h1234_5678_9ABC, 32'h1111_1111, 32'h0808_0808, 0, 1, 48'hFFFF_FFFF_FFFF, 32'h0808_0808, 0, 4, 0};
    tbl[5] = '{1, 0, 48'h6655_4433_2211, 32'h0102_0304, 32'h2222_2222, 1, 0, 48'h6655_4433_2211, 32'h0102_0304, 1, 2, 1};
    tbl[6] = '{1, 0, 48'h0000_0000_000F, 32'hFFFF_FFFF, 32'h3333_3333, 1, 0, 48'h0000_0000_000F, 32'hFFFF_FFFF, 1, 6, 0};
    tbl[7] = '{1, 1, 48'hABCD_EF01_2345, 32'h4444_4444, 32'h7F00_0001, 0, 1, 48'hFFFF_FFFF_FFFF, 32'h7F00_0001, 0, 2, 0};

    rply_mac = '0; rply_ip = '0; rqst_ip = '0;
    do_reset();

    // Reset state of every instance.
    for (int g = 0; g < 3; g++) begin
      check("rst_ctrl", {rr_v[g], qr_v[g], st_v[g], op_v[g], bz_v[g], te_v[g]}, 6'b0);
      check("rst_addr", {mac_v[g], cnt_v[g]}, 64'h0);
      check("rst_ip", ip_v[g], 32'h0);
    end

    // Stray done while idle is ignored.
    sel = 0;
    tx_frame_done = 1;
    step(); step();
    tx_frame_done = 0;
    step();
    check("stray_idle_busy", bz_v[sel], 1'b0);
    check("stray_idle_cnt", cnt_v[sel], 16'd0);

    // Table-driven frames on the default instance.
    foreach (tbl[i]) run_frame(tbl[i], 12);

    // Reset in the middle of a reply frame.
    rply_valid = 1; rply_mac = 48'hDEAD_BEEF_0001; rply_ip = 32'h0A0A_0A0A;
    #1;
    check("midrst_grant", rr_v[sel], 1'b1);
    step();
    rply_valid = 0;
    step(); step();
    check("midrst_busy_before", bz_v[sel], 1'b1);
    areset = 1;
    step();
    areset = 0;
    check("midrst_ctrl", {rr_v[sel], qr_v[sel], st_v[sel], op_v[sel], bz_v[sel], te_v[sel]}, 6'b0);
    check("midrst_mac_cnt", {mac_v[sel], cnt_v[sel]}, 64'h0);
    check("midrst_ip", ip_v[sel], 32'h0);
    exp_cnt = '0;
    run_frame(tbl[0], 12);   // tie goes to reply again: last_grant was reset
    run_frame(tbl[4], 12);   // request-only after that

    // Zero inter-frame gap: ready at D+1, next start at D+2.
    do_reset();
    sel = 1;
    run_frame(tbl[0], 0);
    run_frame(tbl[1], 0);

    // Watchdog: no done after accept at T.
    do_reset();
    sel = 2;
    rply_valid = 1; rply_mac = 48'h0000_1111_2222; rply_ip = 32'h0101_0101;
    #1;
    check("to_grant", rr_v[sel], 1'b1);
    step();
    rply_valid = 0;
    for (int k = 2; k <= 26; k++) begin
      step();
      check($sformatf("to_err_T%0d", k), te_v[sel], TO_EN && (k == 18));
      check($sformatf("to_busy_T%0d", k), bz_v[sel], TO_EN ? (k < 20) : 1'b1);
    end
    check("to_cnt_unchanged", cnt_v[sel], 16'd0);

    // Done in the final watchdog cycle completes normally.
    do_reset();
    rqst_valid = 1; rqst_ip = 32'hC0A8_00FE;
    #1;
    check("to_race_grant", qr_v[sel], 1'b1);
    step();
    rqst_valid = 0;
    repeat (16) step();                       // T+17
    tx_frame_done = 1;
    step();                                   // T+18
    tx_frame_done = 0;
    check("to_race_err", te_v[sel], 1'b0);
    check("to_race_cnt", cnt_v[sel], 16'd1);

    // Randomized traffic against the timestamp model (IFG=2, TIMEOUT=16).
    do_reset();
    m_active = 0; m_last_rply = 0; m_tacc = -100; m_free_at = 0; m_terr = -100;
    m_mac = '0; m_ip = '0; m_oper = 0; m_cnt = '0;
    for (int c = 0; c < 600; c++) begin
      logic idle, e_rr, e_qr;
      rply_valid    = 1'($urandom_range(0, 1));
      rqst_valid    = 1'($urandom_range(0, 1));
      rply_mac      = {16'($urandom), $urandom};
      rply_ip       = $urandom;
      rqst_ip       = $urandom;
      tx_frame_done = ($urandom_range(0, 3) == 0);
      #1;
      idle = !m_active && (c >= m_free_at);
      e_rr = idle && rply_valid && (!rqst_valid || !m_last_rply);
      e_qr = idle && rqst_valid && (!rply_valid || m_last_rply);
      check("rand_ctrl", {rr_v[sel], qr_v[sel], st_v[sel], bz_v[sel], op_v[sel], te_v[sel]},
            {e_rr, e_qr, (c == m_tacc + 1), !idle, m_oper, (c == m_terr)});
      check("rand_mac_cnt", {mac_v[sel], cnt_v[sel]}, {m_mac, m_cnt});
      check("rand_ip", ip_v[sel], m_ip);
      if (e_rr || e_qr) begin
        m_active = 1; m_tacc = c; m_last_rply = e_rr;
        m_mac  = e_rr ? rply_mac : 48'hFFFF_FFFF_FFFF;
        m_ip   = e_rr ? rply_ip : rqst_ip;
        m_oper = e_rr;
      end else if (m_active && c >= m_tacc + 2) begin
        if (tx_frame_done) begin
          m_active = 0; m_free_at = c + 3; m_cnt = m_cnt + 16'd1;
        end else if (TO_EN && (c - (m_tacc + 2) == 15)) begin
          m_active = 0; m_free_at = c + 3; m_terr = c + 1;
        end
      end
      step();
    end
    tx_frame_done = 0; rply_valid = 0; rqst_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
